// File: rtl/dm_pkg.sv
// Shared encodings for the data memory controller: access sizes, FSM states,
// latency counter width and the alignment rule.
package dm_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  localparam int unsigned CNT_W = 3;

  // Half needs an even byte address, word needs all four lanes aligned; size 11 never passes.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lo[0];
      SZ_WORD: bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/data_mem_lane.sv
// Byte-lane steering for the data memory: store lane enables and data replication,
// load lane selection with sign/zero extension.
module data_mem_lane
  import dm_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    be    = '0;
    wword = wdata;
    case (size)
      SZ_BYTE: begin
        be    = 4'b0001 << lane;
        wword = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata[15:0]}};
      end
      SZ_WORD: be = 4'b1111;
      default: be = '0;
    endcase
  end

  always_comb begin
    rbyte = '0;
    case (lane)
      2'd0:    rbyte = rword[7:0];
      2'd1:    rbyte = rword[15:8];
      2'd2:    rbyte = rword[23:16];
      default: rbyte = rword[31:24];
    endcase
    rhalf = lane[1] ? rword[31:16] : rword[15:0];
  end

  always_comb begin
    rdata = '0;
    case (size)
      SZ_BYTE: rdata = is_unsigned ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
      SZ_HALF: rdata = is_unsigned ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
      SZ_WORD: rdata = rword;
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory with valid/ready request/response handshake, programmable latency,
// byte/half/word access and error reporting; one access outstanding at a time.
module data_mem_ctrl
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] TOP_ADDR    = 32'h7FFFFFFC,
  parameter int unsigned LATENCY     = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [29:0] TOP_IDX  = TOP_ADDR[31:2];
  localparam logic [29:0] BASE_IDX = TOP_IDX - 30'(DEPTH_WORDS - 1);
  localparam int unsigned LAST_I   = (LATENCY > 1) ? LATENCY - 2 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = LAST_I[CNT_W-1:0];

  state_e state_q, state_n;
  logic [CNT_W-1:0] cnt_q;

  logic        cap_write, cap_unsigned;
  logic [1:0]  cap_size;
  logic [31:0] cap_addr;

  logic        cur_write, cur_unsigned;
  logic [1:0]  cur_size;
  logic [31:0] cur_addr;
  logic        cur_in_range, cur_err;
  logic [IDX_W-1:0] cur_idx;

  logic [3:0]  be;
  logic [31:0] wword, rword, lane_rdata;
  logic        accept, enter_resp;

  logic [31:0] rdata_q;
  logic        error_q;

  logic [31:0] mem [DEPTH_WORDS];

  // In IDLE the live request drives the datapath (accept edge, LATENCY=1 read);
  // afterwards the captured copy does.
  always_comb begin
    if (state_q == IDLE) begin
      cur_write    = req_write;
      cur_size     = req_size;
      cur_unsigned = req_unsigned;
      cur_addr     = req_addr;
    end else begin
      cur_write    = cap_write;
      cur_size     = cap_size;
      cur_unsigned = cap_unsigned;
      cur_addr     = cap_addr;
    end
  end

  // Only the low IDX_W bits of the offset are needed; modular subtraction keeps them exact.
  always_comb begin
    cur_in_range = (cur_addr[31:2] >= BASE_IDX) && (cur_addr[31:2] <= TOP_IDX);
    cur_err      = misaligned(cur_size, cur_addr[1:0]) || !cur_in_range;
    cur_idx      = cur_in_range ? (cur_addr[IDX_W+1:2] - BASE_IDX[IDX_W-1:0]) : '0;
  end

  assign rword = mem[cur_idx];

  data_mem_lane u_lane (
    .size        (cur_size),
    .is_unsigned (cur_unsigned),
    .lane        (cur_addr[1:0]),
    .wdata       (req_wdata),
    .rword       (rword),
    .be          (be),
    .wword       (wword),
    .rdata       (lane_rdata)
  );

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_error = error_q;

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE: if (accept) state_n = (LATENCY > 1) ? WAIT : RESP;
      WAIT: if (cnt_q == CNT_LAST) state_n = RESP;
      RESP: if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    enter_resp = (state_q != RESP) && (state_n == RESP);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cap_write    <= 1'b0;
      cap_size     <= '0;
      cap_unsigned <= 1'b0;
      cap_addr     <= '0;
      rdata_q      <= '0;
      error_q      <= 1'b0;
    end else begin
      state_q <= state_n;
      if (accept) begin
        cnt_q        <= '0;
        cap_write    <= req_write;
        cap_size     <= req_size;
        cap_unsigned <= req_unsigned;
        cap_addr     <= req_addr;
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (enter_resp) begin
        rdata_q <= (cur_write || cur_err) ? '0 : lane_rdata;
        error_q <= cur_err;
      end else if (state_q == RESP && rsp_ready) begin
        rdata_q <= '0;
        error_q <= 1'b0;
      end
    end
  end

  // Array contents are deliberately not reset; stores commit on the accept edge.
  always_ff @(posedge clock) begin
    if (reset_n && accept && cur_write && !cur_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[cur_idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: three instances with LATENCY 1, 3 and 4.
module tb_data_mem_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  req_valid = '0, req_write = '0, req_unsigned = '0, rsp_ready = '0;
  logic [2:0]  req_ready, rsp_valid, rsp_error;
  logic [1:0]  req_size  [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [31:0] rsp_rdata [3];

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;
  logic        er;

  always #5 clock = ~clock;

  data_mem_ctrl #(.DEPTH_WORDS(256), .TOP_ADDR(32'h7FFFFFFC), .LATENCY(1)) u_l1 (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
    .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_error(rsp_error[0]));

  data_mem_ctrl #(.DEPTH_WORDS(256), .TOP_ADDR(32'h7FFFFFFC), .LATENCY(3)) u_l3 (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
    .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_error(rsp_error[1]));

  data_mem_ctrl #(.DEPTH_WORDS(256), .TOP_ADDR(32'h7FFFFFFC), .LATENCY(4)) u_l4 (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_write(req_write[2]), .req_size(req_size[2]), .req_unsigned(req_unsigned[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .rsp_valid(rsp_valid[2]),
    .rsp_ready(rsp_ready[2]), .rsp_rdata(rsp_rdata[2]), .rsp_error(rsp_error[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd);
    req_write[d]    = w;
    req_size[d]     = sz;
    req_unsigned[d] = u;
    req_addr[d]     = a;
    req_wdata[d]    = wd;
    req_valid[d]    = 1'b1;
  endtask

  task automatic wait_rsp(input int d, output logic [31:0] rdata, output logic err);
    int n = 0;
    while (rsp_valid[d] !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("rsp_timeout", {31'h0, rsp_valid[d]}, 32'h1);
    rdata = rsp_rdata[d];
    err   = rsp_error[d];
    rsp_ready[d] = 1'b1;
    @(posedge clock);
    #1 rsp_ready[d] = 1'b0;
  endtask

  task automatic access(input int d, input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rdata, output logic err);
    int n = 0;
    @(negedge clock);
    drive(d, w, sz, u, a, wd);
    while (req_ready[d] !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("accept_timeout", {31'h0, req_ready[d]}, 32'h1);
    @(posedge clock);
    #1 req_valid[d] = 1'b0;
    wait_rsp(d, rdata, err);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      req_size[i] = '0; req_addr[i] = '0; req_wdata[i] = '0;
    end
    #12;
    for (int i = 0; i < 3; i++) begin
      chk("rst_ready",  {31'h0, req_ready[i]}, 32'h1);
      chk("rst_valid",  {31'h0, rsp_valid[i]}, 32'h0);
      chk("rst_rdata",  rsp_rdata[i], 32'h0);
      chk("rst_error",  {31'h0, rsp_error[i]}, 32'h0);
    end
    @(negedge clock) reset_n = 1'b1;

    // Functional checks on the LATENCY=3 instance
    access(1, 1'b1, 2'b10, 1'b0, 32'h7FFFFFFC, 32'hDEADBEEF, rd, er);
    chk("st_word_rdata", rd, 32'h0);
    chk("st_word_err", {31'h0, er}, 32'h0);
    access(1, 1'b0, 2'b00, 1'b0, 32'h7FFFFFFF, 32'h0, rd, er);
    chk("ld_byte_s", rd, 32'hFFFFFFDE);
    chk("ld_byte_s_err", {31'h0, er}, 32'h0);
    access(1, 1'b0, 2'b01, 1'b1, 32'h7FFFFFFC, 32'h0, rd, er);
    chk("ld_half_u", rd, 32'h0000BEEF);
    access(1, 1'b1, 2'b00, 1'b0, 32'h7FFFFFFD, 32'h00000055, rd, er);
    chk("st_byte_err", {31'h0, er}, 32'h0);
    access(1, 1'b0, 2'b10, 1'b0, 32'h7FFFFFFC, 32'h0, rd, er);
    chk("ld_word_merge", rd, 32'hDEAD55EF);
    access(1, 1'b0, 2'b01, 1'b0, 32'h7FFFFFFD, 32'h0, rd, er);
    chk("misalign_err", {31'h0, er}, 32'h1);
    chk("misalign_rdata", rd, 32'h0);
    access(1, 1'b0, 2'b01, 1'b0, 32'h7FFFFFFE, 32'h0, rd, er);
    chk("ld_half_s", rd, 32'hFFFFDEAD);
    access(1, 1'b0, 2'b00, 1'b1, 32'h7FFFFFFF, 32'h0, rd, er);
    chk("ld_byte_u", rd, 32'h000000DE);
    access(1, 1'b1, 2'b01, 1'b0, 32'h7FFFFFFE, 32'hA5A58001, rd, er);
    access(1, 1'b0, 2'b10, 1'b0, 32'h7FFFFFFC, 32'h0, rd, er);
    chk("st_half_upper", rd, 32'h800155EF);

    access(1, 1'b1, 2'b10, 1'b0, 32'h7FFFFC00, 32'h12345678, rd, er);
    access(1, 1'b1, 2'b10, 1'b0, 32'h7FFFFBFC, 32'hFFFFFFFF, rd, er);
    chk("below_base_err", {31'h0, er}, 32'h1);
    access(1, 1'b0, 2'b10, 1'b0, 32'h7FFFFC00, 32'h0, rd, er);
    chk("base_intact", rd, 32'h12345678);
    chk("base_err", {31'h0, er}, 32'h0);
    access(1, 1'b0, 2'b11, 1'b0, 32'h7FFFFFFC, 32'h0, rd, er);
    chk("size11_err", {31'h0, er}, 32'h1);
    chk("size11_rdata", rd, 32'h0);
    access(1, 1'b0, 2'b10, 1'b0, 32'h80000000, 32'h0, rd, er);
    chk("above_top_err", {31'h0, er}, 32'h1);

    // Latency 3 timing, response hold and no same-cycle turnaround
    @(negedge clock);
    drive(1, 1'b0, 2'b10, 1'b0, 32'h7FFFFFFC, 32'h0);
    chk("l3_ready_pre", {31'h0, req_ready[1]}, 32'h1);
    @(posedge clock); #1;
    drive(1, 1'b0, 2'b00, 1'b1, 32'h7FFFFFFC, 32'h0);
    chk("l3_ready_n", {31'h0, req_ready[1]}, 32'h0);
    chk("l3_valid_n", {31'h0, rsp_valid[1]}, 32'h0);
    @(posedge clock); #1;
    chk("l3_valid_n1", {31'h0, rsp_valid[1]}, 32'h0);
    @(posedge clock); #1;
    chk("l3_valid_n2", {31'h0, rsp_valid[1]}, 32'h1);
    chk("l3_rdata", rsp_rdata[1], 32'h800155EF);
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      chk("hold_valid", {31'h0, rsp_valid[1]}, 32'h1);
      chk("hold_rdata", rsp_rdata[1], 32'h800155EF);
      chk("hold_ready", {31'h0, req_ready[1]}, 32'h0);
    end
    @(negedge clock) rsp_ready[1] = 1'b1;
    @(posedge clock); #1 rsp_ready[1] = 1'b0;
    chk("hs_valid", {31'h0, rsp_valid[1]}, 32'h0);
    chk("hs_rdata", rsp_rdata[1], 32'h0);
    chk("hs_ready", {31'h0, req_ready[1]}, 32'h1);
    @(posedge clock); #1 req_valid[1] = 1'b0;
    chk("second_accept", {31'h0, req_ready[1]}, 32'h0);
    wait_rsp(1, rd, er);
    chk("second_rdata", rd, 32'h000000EF);

    // LATENCY=1: response visible right after the accept edge
    access(0, 1'b1, 2'b10, 1'b0, 32'h7FFFFFF0, 32'h11228384, rd, er);
    @(negedge clock);
    drive(0, 1'b0, 2'b00, 1'b0, 32'h7FFFFFF1, 32'h0);
    @(posedge clock); #1 req_valid[0] = 1'b0;
    chk("l1_valid", {31'h0, rsp_valid[0]}, 32'h1);
    chk("l1_rdata", rsp_rdata[0], 32'hFFFFFF83);
    wait_rsp(0, rd, er);

    // LATENCY=4: reset during WAIT keeps the committed store
    @(negedge clock);
    drive(2, 1'b1, 2'b10, 1'b0, 32'h7FFFFFF8, 32'hCAFEF00D);
    @(posedge clock); #1 req_valid[2] = 1'b0;
    chk("l4_wait_ready", {31'h0, req_ready[2]}, 32'h0);
    @(posedge clock); #1;
    chk("l4_wait_valid", {31'h0, rsp_valid[2]}, 32'h0);
    @(negedge clock) reset_n = 1'b0;
    #1;
    chk("midrst_valid", {31'h0, rsp_valid[2]}, 32'h0);
    chk("midrst_ready", {31'h0, req_ready[2]}, 32'h1);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;
    chk("postrst_ready", {31'h0, req_ready[2]}, 32'h1);
    chk("postrst_valid", {31'h0, rsp_valid[2]}, 32'h0);
    access(2, 1'b0, 2'b10, 1'b0, 32'h7FFFFFF8, 32'h0, rd, er);
    chk("postrst_store", rd, 32'hCAFEF00D);
    access(1, 1'b0, 2'b10, 1'b0, 32'h7FFFFFFC, 32'h0, rd, er);
    chk("postrst_l3_mem", rd, 32'h800155EF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
